// File: rtl/mdu_pkg.sv
// Shared definitions for the sequential multiply/divide unit.
package mdu_pkg;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'b00,
        MDU_MULTU = 2'b01,
        MDU_DIV   = 2'b10,
        MDU_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        SIGN = 2'b10,
        DONE = 2'b11
    } mdu_state_e;

    localparam int MDU_ITER = 32;
    localparam int CNT_W    = $clog2(MDU_ITER);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MDU_ITER - 1);

    // Magnitude of a 32-bit operand; only negative signed values are negated.
    // 0x80000000 maps to itself, which is the correct unsigned magnitude.
    function automatic logic [31:0] mag32(input logic [31:0] v, input logic sgn);
        return (sgn && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/mdu_addsub.sv
// 33-bit adder/subtractor shared by the multiply and divide steps.
// cout is the true carry out; on subtract, cout=1 means no borrow (a >= b).
module mdu_addsub (
    input  logic [32:0] a,
    input  logic [32:0] b,
    input  logic        sub,
    output logic [32:0] y,
    output logic        cout
);

    logic [33:0] sum;

    // Subtract is a + ~b + 1.
    assign sum  = {1'b0, a} + {1'b0, (sub ? ~b : b)} + {33'd0, sub};
    assign y    = sum[32:0];
    assign cout = sum[33];

endmodule

// File: rtl/mdu_seq.sv
// Sequential radix-2 multiply/divide unit with HI/LO result registers.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | waiting; start captures operands, mthi/mtlo write hi/lo
//   RUN   | 32 radix-2 steps (shift-add or restoring divide) on magnitudes
//   SIGN  | apply sign fixup / divide-by-zero result, write hi and lo
//   DONE  | one-cycle result-valid; start here chains the next operation
module mdu_seq
    import mdu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] srca,
    input  logic [31:0] srcb,
    input  logic        mthi,
    input  logic        mtlo,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    mdu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    mdu_op_e          op_q, op_d;
    // acc: multiply = {partial product high, multiplier/product low};
    //      divide   = {remainder, dividend/quotient}
    logic [63:0]      acc_q, acc_d;
    logic [31:0]      bmag_q, bmag_d;
    logic [31:0]      araw_q, araw_d;
    logic             neg_q, neg_d;
    logic             neg_rem_q, neg_rem_d;
    logic             divz_q, divz_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [32:0]      as_a;
    logic [32:0]      as_b;
    logic             as_sub;
    logic [32:0]      as_y;
    logic             as_cout;

    logic [63:0]      prod_neg;
    logic [31:0]      quo_neg;
    logic [31:0]      rem_neg;
    logic             cap_sgn;
    logic [32:0]      mul_sum;

    // Divide feeds the shifted remainder; multiply feeds the zero-extended high half.
    assign as_a   = op_q[1] ? {acc_q[63:32], acc_q[31]} : {1'b0, acc_q[63:32]};
    assign as_b   = {1'b0, bmag_q};
    assign as_sub = op_q[1];

    mdu_addsub u_addsub (
        .a    (as_a),
        .b    (as_b),
        .sub  (as_sub),
        .y    (as_y),
        .cout (as_cout)
    );

    assign prod_neg = ~acc_q + 64'd1;
    assign quo_neg  = ~acc_q[31:0] + 32'd1;
    assign rem_neg  = ~acc_q[63:32] + 32'd1;
    assign cap_sgn  = ~op[0];
    assign mul_sum  = acc_q[0] ? as_y : {1'b0, acc_q[63:32]};

    // Next-state, datapath step and registered output computation.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        acc_d     = acc_q;
        bmag_d    = bmag_q;
        araw_d    = araw_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        divz_d    = divz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    op_d      = mdu_op_e'(op);
                    acc_d     = {32'd0, mag32(srca, cap_sgn)};
                    bmag_d    = mag32(srcb, cap_sgn);
                    araw_d    = srca;
                    neg_d     = cap_sgn & (srca[31] ^ srcb[31]);
                    neg_rem_d = cap_sgn & srca[31];
                    divz_d    = op[1] & (srcb == 32'd0);
                    cnt_d     = '0;
                    state_d   = RUN;
                end else begin
                    state_d = IDLE;
                    if (mthi) hi_d = srca;
                    if (mtlo) lo_d = srca;
                end
            end
            RUN: begin
                if (op_q[1]) begin
                    // Restoring step: keep the difference only when it did not borrow.
                    if (as_cout) acc_d = {as_y[31:0], acc_q[30:0], 1'b1};
                    else         acc_d = {acc_q[62:0], 1'b0};
                end else begin
                    acc_d = {mul_sum, acc_q[31:1]};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) state_d = SIGN;
            end
            SIGN: begin
                if (op_q[1]) begin
                    if (divz_q) begin
                        lo_d = 32'hFFFF_FFFF;
                        hi_d = araw_q;
                    end else begin
                        lo_d = neg_q     ? quo_neg : acc_q[31:0];
                        hi_d = neg_rem_q ? rem_neg : acc_q[63:32];
                    end
                end else begin
                    lo_d = neg_q ? prod_neg[31:0]  : acc_q[31:0];
                    hi_d = neg_q ? prod_neg[63:32] : acc_q[63:32];
                end
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == RUN) || (state_d == SIGN);
        done_d = (state_d == DONE);
    end

    // All state, with synchronous reset taking priority over everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            op_q      <= MDU_MULT;
            acc_q     <= '0;
            bmag_q    <= '0;
            araw_q    <= '0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            divz_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            acc_q     <= acc_d;
            bmag_q    <= bmag_d;
            araw_q    <= araw_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
            divz_q    <= divz_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_seq.sv
// Directed bench for mdu_seq: vector table plus hand-written multi-cycle sequences.
module tb_mdu_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] srca;
    logic [31:0] srcb;
    logic        mthi;
    logic        mtlo;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[13];

    mdu_seq dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .srca  (srca),
        .srcb  (srcb),
        .mthi  (mthi),
        .mtlo  (mtlo),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Drive a start request at the current (negedge) time; returns just after edge k.
    task automatic apply(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        op    = o;
        srca  = a;
        srcb  = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        mthi  = 1'b0;
        mtlo  = 1'b0;
    endtask

    // Cycles after edges k..k+32 must show busy, no done, and unchanged hi/lo;
    // the cycle after k+33 must show done and the expected result.
    // inj>=0 injects a rejected start at that cycle and a rejected mthi/mtlo after it.
    task automatic wait_result(input logic [31:0] eh, input logic [31:0] el,
                               input logic [31:0] ph, input logic [31:0] pl,
                               input int inj, input string name);
        bit          bad = 0;
        logic [31:0] bh = '0;
        logic [31:0] bl = '0;
        int          bj = -1;
        for (int j = 0; j < 33; j++) begin
            @(negedge clk);
            if (!bad && (busy !== 1'b1 || done !== 1'b0 || hi !== ph || lo !== pl)) begin
                bad = 1;
                bh  = hi;
                bl  = lo;
                bj  = j;
            end
            if (inj >= 0 && j == inj) begin
                start = 1'b1;
                op    = 2'b11;
                srca  = 32'h0000_0099;
                srcb  = 32'h0000_0003;
            end else if (inj >= 0 && j == inj + 1) begin
                start = 1'b0;
                srca  = 32'h1234_5678;
                mthi  = 1'b1;
                mtlo  = 1'b1;
            end else if (inj >= 0 && j == inj + 2) begin
                mthi  = 1'b0;
                mtlo  = 1'b0;
            end
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL %s_busy_hold: cycle %0d got busy=%b done=%b hi=%h lo=%h required busy=1 done=0 hi=%h lo=%h",
                     name, bj, busy, done, bh, bl, ph, pl);
        end
        @(negedge clk);
        chk({name, "_done"}, 32'({busy, done}), 32'b01);
        chk({name, "_hi"}, hi, eh);
        chk({name, "_lo"}, lo, el);
    endtask

    initial begin
        logic [31:0] ph;
        logic [31:0] pl;
        bit          bad;

        vecs[0]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[1]  = '{2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
        vecs[2]  = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3]  = '{2'b11, 32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF};
        vecs[4]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[5]  = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF};
        vecs[6]  = '{2'b01, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000};
        vecs[7]  = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[8]  = '{2'b11, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF};
        vecs[9]  = '{2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
        vecs[10] = '{2'b00, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0001};
        vecs[11] = '{2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000};
        vecs[12] = '{2'b10, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0003};

        reset = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        srca  = '0;
        srcb  = '0;
        mthi  = 1'b0;
        mtlo  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("reset_busy_done", 32'({busy, done}), 32'b00);
        chk("reset_hi", hi, 32'h0);
        chk("reset_lo", lo, 32'h0);

        // Idle register moves.
        mthi = 1'b1; srca = 32'hAAAA_5555;
        @(negedge clk);
        mthi = 1'b0;
        chk("mthi_hi", hi, 32'hAAAA_5555);
        chk("mthi_lo_untouched", lo, 32'h0);
        mtlo = 1'b1; srca = 32'h0F0F_0F0F;
        @(negedge clk);
        mtlo = 1'b0;
        chk("mtlo_lo", lo, 32'h0F0F_0F0F);
        chk("mtlo_hi_untouched", hi, 32'hAAAA_5555);
        mthi = 1'b1; mtlo = 1'b1; srca = 32'h1122_3344;
        @(negedge clk);
        chk("mtboth_hi", hi, 32'h1122_3344);
        chk("mtboth_lo", lo, 32'h1122_3344);

        // mthi/mtlo still asserted together with start: the moves must be ignored.
        apply(2'b01, 32'h0000_0002, 32'h0000_0003);
        wait_result(32'h0, 32'h6, 32'h1122_3344, 32'h1122_3344, -1, "start_vs_mt");
        @(negedge clk);
        chk("start_vs_mt_done_drop", 32'(done), 32'b0);
        ph = 32'h0;
        pl = 32'h6;

        for (int i = 0; i < 13; i++) begin
            apply(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_result(vecs[i].hi, vecs[i].lo, ph, pl, -1, $sformatf("vec%0d", i));
            @(negedge clk);
            chk($sformatf("vec%0d_done_drop", i), 32'(done), 32'b0);
            ph = vecs[i].hi;
            pl = vecs[i].lo;
        end

        // Back-to-back: start in DONE, previous result stays visible meanwhile.
        apply(2'b00, 32'hFFFF_FFFD, 32'h0000_0007);
        wait_result(32'hFFFF_FFFF, 32'hFFFF_FFEB, ph, pl, -1, "b2b_first");
        apply(2'b10, 32'hFFFF_FFF9, 32'h0000_0002);
        wait_result(32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, -1, "b2b_second");
        @(negedge clk);
        chk("b2b_done_drop", 32'(done), 32'b0);

        // Busy-time rejection of start (RUN cycle 5) and of mthi/mtlo.
        apply(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_result(32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 5, "reject");
        bad = 0;
        for (int j = 0; j < 40; j++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) bad = 1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL reject_single_done: got extra busy/done after result, required none");
        end
        chk("reject_hi_kept", hi, 32'hFFFF_FFFE);

        // Reset in the middle of RUN aborts the operation.
        apply(2'b00, 32'h0000_1234, 32'h0000_5678);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("abort_busy_done", 32'({busy, done}), 32'b00);
        chk("abort_hi", hi, 32'h0);
        chk("abort_lo", lo, 32'h0);
        bad = 0;
        for (int j = 0; j < 40; j++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) bad = 1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL abort_no_late_result: got done/busy/result after reset, required none");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mdu_seq.md
MDU_SEQ -- requirements
Module: mdu_seq

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-high.
REQ-003 start  input  1  request a new operation; sampled on clk.
REQ-004 op  input  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-005 srca  input  32  operand A (rs); dividend for DIV/DIVU.
REQ-006 srcb  input  32  operand B (rt); divisor for DIV/DIVU.
REQ-007 mthi  input  1  write srca into hi.
REQ-008 mtlo  input  1  write srca into lo.
REQ-009 busy  output  1  operation in progress.
REQ-010 done  output  1  one-cycle pulse: hi/lo hold a fresh result.
REQ-011 hi  output  32  HI register (product[63:32] or remainder).
REQ-012 lo  output  32  LO register (product[31:0] or quotient).

Function
REQ-013 The FSM SHALL have exactly four states: IDLE, RUN, SIGN, DONE.
REQ-014 In IDLE or DONE, start=1 SHALL capture op, srca and srcb, clear the iteration counter, and go to RUN.
REQ-015 In IDLE or DONE, start=0 SHALL go to (or stay in) IDLE.
REQ-016 RUN SHALL last exactly 32 cycles, one radix-2 step per cycle, then go to SIGN.
- Multiply: shift-add on 32-bit magnitudes into a 64-bit accumulator.
- Divide: restoring divide using a 33-bit subtract on magnitudes.
REQ-017 SIGN SHALL last one cycle, apply the sign fixup, write hi/lo, then go to DONE.
REQ-018 Latency: with start sampled at edge k, hi/lo SHALL update at edge k+33, and done SHALL be 1 only in the cycle after that edge.
REQ-019 busy SHALL be 1 exactly in RUN and SIGN.
REQ-020 done SHALL be 1 exactly in DONE.
REQ-021 start while busy=1 SHALL be ignored; the operation in flight is not affected.
REQ-022 MULT/DIV SHALL treat operands as two's complement; MULTU/DIVU SHALL treat them as unsigned.
REQ-023 Signed multiply: the 64-bit product SHALL be negated when the operand signs differ.
REQ-024 Signed divide sign rules:
- quotient negated when the operand signs differ;
- remainder takes the sign of the dividend.
REQ-025 DIV 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000, hi=0x00000000.
REQ-026 Divide by zero (srcb=0), signed or unsigned, SHALL give lo=0xFFFFFFFF, hi=srca, with the same 33-edge latency and a done pulse.
REQ-027 mthi/mtlo SHALL write hi/lo from srca at the clock edge only when busy=0 and start=0.
- Otherwise they are ignored.
- Asserting both in the same cycle writes both registers.
REQ-028 hi/lo SHALL hold their value except at the SIGN→DONE edge and on an accepted mthi/mtlo write.
REQ-029 Back-to-back: start=1 in DONE SHALL begin a new operation with no idle cycle, and the hi/lo just written SHALL stay visible until the new result is written.

Reset
REQ-030 reset=1 at a clock edge SHALL force state to IDLE and clear hi, lo, the counter and all datapath registers to 0.
- busy=0 and done=0 from the following cycle.
REQ-031 Reset SHALL take priority over start, mthi and mtlo in every state.
REQ-032 Reset mid-operation SHALL abort the operation: no done pulse and no later write of its result.

Structure
REQ-033 Shared package mdu_pkg SHALL define:
- op encodings MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU;
- the state enum;
- the constant MDU_ITER=32.
REQ-034 One sub-module, mdu_addsub, SHALL implement the 33-bit add/subtract shared by the multiply and divide steps.
REQ-035 Everything else (FSM, counter, sign fixup, hi/lo) SHALL be in mdu_seq.

Verification
REQ-036 MULTU 0xFFFFFFFF×0xFFFFFFFF
- start at edge k → hi=0xFFFFFFFE, lo=0x00000001;
- done high only in the cycle after edge k+33;
- busy high for 33 cycles.
REQ-037 MULT 0xFFFFFFFD×0x00000007 (-3×7) → hi=0xFFFFFFFF, lo=0xFFFFFFEB.
REQ-038 DIV 0xFFFFFFF9/0x00000002 (-7/2) → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-039 Divide edge cases:
- DIVU 0x00000064/0 → lo=0xFFFFFFFF, hi=0x00000064;
- DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
REQ-040 Busy-time input rejection:
- start with new operands at RUN cycle 5 → first result unchanged and only one done pulse;
- mthi with srca=0x12345678 while busy → hi not written.
REQ-041 reset at RUN cycle 10 → next cycle busy=0, done=0, hi=lo=0, and no done pulse within the following 40 cycles.
